// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory: access size codes, controller
// state encoding and the byte-offset width helper.
package data_memory_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Number of byte-offset address bits inside one memory word.
  function automatic int off_width(input int data_w);
    return (data_w == 64) ? 3 : 2;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response bundle between the pipeline MEM stage (master) and the
// data memory (slave).
interface data_memory_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  import data_memory_pkg::*;

  localparam int OFF_W = off_width(DATA_W);

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [1:0]               req_size;
  logic                     req_unsigned;
  logic [ADDR_W+OFF_W-1:0]  req_addr;
  logic [DATA_W-1:0]        req_wdata;
  logic                     rsp_valid;
  logic [DATA_W-1:0]        rsp_data;
  logic                     rsp_err;
  logic                     init_done;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err, init_done
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_err, init_done
  );

endinterface

// File: rtl/data_memory_align.sv
// Combinational byte-lane logic: store lane mask and data shift, load
// extraction with sign/zero extension, and misalign/illegal-size detection.
module data_memory_align
  import data_memory_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]                  size,
  input  logic                        zero_ext,
  input  logic [off_width(DATA_W)-1:0] offset,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [DATA_W-1:0]           rdata,
  output logic [DATA_W/8-1:0]         lane_mask,
  output logic [DATA_W-1:0]           wdata_shifted,
  output logic [DATA_W-1:0]           load_data,
  output logic                        err
);

  localparam int OFF_W = off_width(DATA_W);
  localparam int LANES = DATA_W / 8;

  logic [OFF_W-1:0]  align_mask;
  logic [LANES-1:0]  size_mask;
  logic [OFF_W+2:0]  bit_shift;
  logic [DATA_W-1:0] shifted;
  logic              illegal;
  logic              misaligned;
  logic              top_bit;
  logic              fill;
  int                nbits;

  assign bit_shift = {offset, 3'b000};

  // Decode the access size into an alignment mask, a lane mask at offset 0
  // and the number of meaningful load bits; flag bad requests.
  always_comb begin
    align_mask = '0;
    size_mask  = '0;
    nbits      = DATA_W;
    case (size)
      SZ_B: begin
        align_mask = OFF_W'(0);
        size_mask  = LANES'(1);
        nbits      = 8;
      end
      SZ_H: begin
        align_mask = OFF_W'(1);
        size_mask  = LANES'(3);
        nbits      = 16;
      end
      SZ_W: begin
        align_mask = OFF_W'(3);
        size_mask  = LANES'(15);
        nbits      = 32;
      end
      default: begin
        align_mask = OFF_W'(7);
        size_mask  = LANES'(255);
        nbits      = 64;
      end
    endcase
    if (nbits > DATA_W) begin
      nbits = DATA_W;
    end
    illegal    = (size == SZ_D) && (DATA_W < 64);
    misaligned = |(offset & align_mask);
    err        = illegal | misaligned;
  end

  // Store path: position the lane mask and data at the byte offset; a bad
  // request enables no lanes so nothing is written.
  always_comb begin
    wdata_shifted = wdata << bit_shift;
    lane_mask     = err ? '0 : (size_mask << offset);
  end

  // Load path: bring the addressed bytes down to bit 0, then extend from the
  // top bit of the access width (or with zeros for unsigned loads).
  always_comb begin
    shifted = rdata >> bit_shift;
    top_bit = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == nbits - 1) begin
        top_bit = shifted[i];
      end
    end
    fill = ~zero_ext & top_bit;
    load_data = '0;
    for (int i = 0; i < DATA_W; i++) begin
      load_data[i] = (i < nbits) ? shifted[i] : fill;
    end
    if (err) begin
      load_data = '0;
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory for the MEM stage. After reset a sequencer
// writes the preload pattern into every word, then requests are served with
// a fixed two-edge response latency.
module data_memory_ctrl
  import data_memory_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int PRELOAD = 8
) (
  input logic          clk,
  input logic          rst_n,
  data_memory_if.slave bus
);

  localparam int OFF_W = off_width(DATA_W);
  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_next;
  logic [DATA_W-1:0] init_word;

  logic              accept;
  logic [ADDR_W-1:0] word_idx;
  logic [OFF_W-1:0]  offset;
  logic [DATA_W-1:0] rdata;
  logic [LANES-1:0]  lane_mask;
  logic [DATA_W-1:0] wdata_shifted;
  logic [DATA_W-1:0] load_data;
  logic              align_err;

  logic              pend_valid;
  logic              pend_err;
  logic [DATA_W-1:0] pend_data;

  assign word_idx = bus.req_addr[ADDR_W+OFF_W-1:OFF_W];
  assign offset   = bus.req_addr[OFF_W-1:0];
  assign rdata    = mem[word_idx];
  assign accept   = bus.req_valid && bus.req_ready;

  // Words 1..PRELOAD hold their own index, everything else starts at zero.
  assign init_word = ((int'(cnt) >= 1) && (int'(cnt) <= PRELOAD))
                     ? DATA_W'(cnt) : '0;

  data_memory_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .size          (bus.req_size),
    .zero_ext      (bus.req_unsigned),
    .offset        (offset),
    .wdata         (bus.req_wdata),
    .rdata         (rdata),
    .lane_mask     (lane_mask),
    .wdata_shifted (wdata_shifted),
    .load_data     (load_data),
    .err           (align_err)
  );

  // Controller state and preload counter; reset always restarts the preload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Walk the counter through every word during INIT, then serve requests.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    bus.req_ready = 1'b0;
    bus.init_done = 1'b0;
    case (state)
      ST_INIT: begin
        cnt_next = cnt + ADDR_W'(1);
        if (cnt == ADDR_W'(DEPTH - 1)) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        bus.req_ready = 1'b1;
        bus.init_done = 1'b1;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  // Array write port: preload words during INIT, byte-lane stores in RUN.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[cnt] <= init_word;
    end else if (accept && bus.req_we) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_mask[l]) begin
          mem[word_idx][l*8 +: 8] <= wdata_shifted[l*8 +: 8];
        end
      end
    end
  end

  // Capture the response at acceptance, present it one edge later; data and
  // error stay zero whenever no response is being presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid    <= 1'b0;
      pend_err      <= 1'b0;
      pend_data     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_data  <= '0;
    end else begin
      pend_valid    <= accept;
      pend_err      <= accept && align_err;
      pend_data     <= (accept && !bus.req_we && !align_err) ? load_data : '0;
      bus.rsp_valid <= pend_valid;
      bus.rsp_err   <= pend_err;
      bus.rsp_data  <= pend_data;
    end
  end

endmodule
